// File: rtl/peripheral_bin2bcd.sv
// rtl/peripheral_bin2bcd.sv - memory-mapped iterative double-dabble binary-to-BCD converter
module peripheral_bin2bcd #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] d_in,
  input  logic        cs,
  input  logic [4:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [31:0] d_out
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [4:0] A_DATA   = 5'h00;
  localparam logic [4:0] A_CTRL   = 5'h04;
  localparam logic [4:0] A_STATUS = 5'h08;
  localparam logic [4:0] A_RESULT = 5'h0C;

  typedef enum logic {IDLE, CONV} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0]    operand, op_in, mag_in;
  logic [BW+WIDTH-1:0] shreg, shifted;   // {bcd digits, remaining magnitude bits}
  logic [BW-1:0]       result, bcd_adj;
  logic [CW-1:0]       count;
  logic                signed_mode, done, err, sign, neg_in;
  logic                busy, load, shift_en, finish;
  logic                wr_en, rd_en, data_wr;
  logic [31:0]         rd_data;
  logic                unused_bits;

  assign wr_en   = cs & wr;
  assign rd_en   = cs & rd;
  assign data_wr = wr_en && (addr == A_DATA);

  assign op_in  = d_in[WIDTH-1:0];
  assign neg_in = signed_mode & op_in[WIDTH-1];
  assign mag_in = neg_in ? (~op_in + WIDTH'(1)) : op_in;

  assign unused_bits = ^{d_in[31:WIDTH], bcd_adj[BW-1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (data_wr) state_nxt = CONV;
      CONV:    if (count == CW'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == CONV);
    load     = (state == IDLE) && data_wr;
    shift_en = busy;
    finish   = busy && (count == CW'(1));
  end

  // Add-3 correction precedes the shift so the final shift leaves clean digits.
  always_comb begin
    bcd_adj = shreg[BW+WIDTH-1:WIDTH];
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_adj[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
    end
    shifted = {bcd_adj[BW-2:0], shreg[WIDTH-1:0], 1'b0};
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      A_DATA:   rd_data[WIDTH-1:0] = operand;
      A_CTRL:   rd_data[0]         = signed_mode;
      A_STATUS: rd_data[3:0]       = {sign, err, done, busy};
      A_RESULT: rd_data[BW-1:0]    = result;
      default:  rd_data            = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      operand     <= '0;
      shreg       <= '0;
      result      <= '0;
      count       <= '0;
      signed_mode <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      sign        <= 1'b0;
      d_out       <= '0;
    end else begin
      if (rd_en && (addr == A_RESULT) && done) done <= 1'b0;
      if (load) begin
        operand <= op_in;
        sign    <= neg_in;
        shreg   <= {{BW{1'b0}}, mag_in};
        count   <= CW'(WIDTH);
        done    <= 1'b0;
      end else if (shift_en) begin
        shreg <= shifted;
        count <= count - CW'(1);
        if (finish) begin
          result <= shifted[BW+WIDTH-1:WIDTH];
          done   <= 1'b1;
        end
      end
      if (wr_en && (addr == A_CTRL)) begin
        signed_mode <= d_in[0];
        if (d_in[1]) err <= 1'b0;
      end
      if (data_wr && busy) err <= 1'b1;
      if (rd_en) d_out <= rd_data;
    end
  end
endmodule

// File: tb/tb_peripheral_bin2bcd.sv
// tb/tb_peripheral_bin2bcd.sv - directed bench with a register-level reference model
`timescale 1ns/1ps
module tb_peripheral_bin2bcd;
  localparam int W  = 16;
  localparam int D  = 5;
  localparam int W2 = 26;
  localparam int D2 = 8;
  localparam logic [4:0] A_DATA = 5'h00, A_CTRL = 5'h04, A_STATUS = 5'h08;
  localparam logic [4:0] A_RESULT = 5'h0C, A_UNMAP = 5'h1C;

  logic        clk = 0, reset = 1, cs = 0, cs2 = 0, rd = 0, wr = 0;
  logic [4:0]  addr = '0;
  logic [31:0] d_in = '0, d_out, d_out2, v;
  int          tests = 0, fails = 0;
  bit          chk_en = 0;

  always #5 clk = ~clk;

  peripheral_bin2bcd #(.WIDTH(W), .DIGITS(D)) dut (
    .clk(clk), .reset(reset), .d_in(d_in), .cs(cs), .addr(addr),
    .rd(rd), .wr(wr), .d_out(d_out));

  peripheral_bin2bcd #(.WIDTH(W2), .DIGITS(D2)) dut2 (
    .clk(clk), .reset(reset), .d_in(d_in), .cs(cs2), .addr(addr),
    .rd(rd), .wr(wr), .d_out(d_out2));

  // Register-level model of the W=16 instance: conversion is a countdown plus decimal arithmetic.
  logic [31:0] m_operand, m_result, exp_dout;
  bit          m_signed, m_done, m_err, m_sign;
  int          m_left;
  longint      m_mag;

  function automatic logic [31:0] to_bcd(longint x);
    logic [31:0] r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] mread(logic [4:0] a);
    case (a)
      A_DATA:   return m_operand;
      A_CTRL:   return {31'd0, m_signed};
      A_STATUS: return {28'd0, m_sign, m_err, m_done, (m_left > 0)};
      A_RESULT: return m_result;
      default:  return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_operand = '0; m_result = '0; exp_dout = '0;
    m_signed = 0; m_done = 0; m_err = 0; m_sign = 0; m_left = 0; m_mag = 0;
  endtask

  task automatic model_edge();
    bit busy;
    busy = (m_left > 0);
    if (cs && rd) begin
      exp_dout = mread(addr);
      if (addr == A_RESULT && m_done) m_done = 0;
    end
    if (busy) begin
      m_left--;
      if (m_left == 0) begin
        m_result = to_bcd(m_mag);
        m_done = 1;
      end
    end
    if (cs && wr) begin
      if (addr == A_DATA) begin
        if (busy) m_err = 1;
        else begin
          m_operand = d_in & ((32'h1 << W) - 1);
          m_sign = m_signed && m_operand[W-1];
          m_mag = m_sign ? ((longint'(1) << W) - longint'(m_operand)) : longint'(m_operand);
          m_left = W;
          m_done = 0;
        end
      end else if (addr == A_CTRL) begin
        m_signed = d_in[0];
        if (d_in[1]) m_err = 0;
      end
    end
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (chk_en) check("d_out vs model", d_out, exp_dout);

  task automatic tick();
    @(posedge clk);
    if (!reset) model_edge();
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic wr_reg(bit sel2, logic [4:0] a, logic [31:0] x);
    cs = !sel2; cs2 = sel2; wr = 1; addr = a; d_in = x;
    tick();
    cs = 0; cs2 = 0; wr = 0;
  endtask

  task automatic rchk(bit sel2, logic [4:0] a, logic [31:0] exp, string name);
    cs = !sel2; cs2 = sel2; rd = 1; addr = a;
    tick();
    cs = 0; cs2 = 0; rd = 0;
    @(negedge clk);
    check(name, sel2 ? d_out2 : d_out, exp);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk_en = 1;

    rchk(0, A_DATA, 32'h0, "reset DATA");
    rchk(0, A_CTRL, 32'h0, "reset CTRL");
    rchk(0, A_STATUS, 32'h0, "reset STATUS");
    rchk(0, A_RESULT, 32'h0, "reset RESULT");

    wr_reg(0, A_DATA, 32'd255);
    idle(W);
    rchk(0, A_STATUS, 32'h2, "255 STATUS done");
    rchk(0, A_RESULT, 32'h255, "255 RESULT");
    check("model 255", m_result, 32'h255);
    rchk(0, A_STATUS, 32'h0, "255 DONE cleared");

    wr_reg(0, A_DATA, 32'd65535);
    for (int k = 1; k <= W; k++) begin
      rchk(0, A_STATUS, 32'h1, $sformatf("65535 busy cycle %0d", k));
    end
    rchk(0, A_STATUS, 32'h2, "65535 idle after 16");
    rchk(0, A_RESULT, 32'h65535, "65535 RESULT");

    wr_reg(0, A_CTRL, 32'h1);
    rchk(0, A_CTRL, 32'h1, "CTRL signed");
    wr_reg(0, A_DATA, 32'hFFFF);
    idle(W);
    rchk(0, A_STATUS, 32'hA, "-1 STATUS sign");
    rchk(0, A_RESULT, 32'h1, "-1 RESULT");
    wr_reg(0, A_DATA, 32'h8000);
    idle(W);
    rchk(0, A_STATUS, 32'hA, "-32768 STATUS");
    rchk(0, A_RESULT, 32'h32768, "-32768 RESULT");
    check("model 32768", m_result, 32'h32768);
    rchk(0, A_DATA, 32'h8000, "DATA raw operand");
    wr_reg(0, A_DATA, 32'h7FFF);
    idle(W);
    rchk(0, A_STATUS, 32'h2, "32767 STATUS");
    rchk(0, A_RESULT, 32'h32767, "32767 RESULT");

    wr_reg(0, A_CTRL, 32'h0);
    wr_reg(0, A_DATA, 32'd100);
    idle(2);
    wr_reg(0, A_DATA, 32'd9);
    idle(W - 3);
    rchk(0, A_STATUS, 32'h6, "overlap STATUS err");
    rchk(0, A_RESULT, 32'h100, "overlap RESULT");
    rchk(0, A_DATA, 32'd100, "overlap DATA kept");
    wr_reg(0, A_CTRL, 32'h2);
    rchk(0, A_STATUS, 32'h0, "ERR cleared");
    rchk(0, A_CTRL, 32'h0, "CTRL bit1 reads 0");

    wr_reg(0, A_DATA, 32'd7);
    idle(W - 1);
    wr_reg(0, A_DATA, 32'd8);
    wr_reg(0, A_DATA, 32'd9);
    idle(W);
    rchk(0, A_RESULT, 32'h9, "write at E_W+1 accepted");
    rchk(0, A_STATUS, 32'h4, "write at E_W rejected");
    wr_reg(0, A_CTRL, 32'h2);

    cs = 1; rd = 1; wr = 1; addr = A_CTRL; d_in = 32'h1;
    tick();
    cs = 0; rd = 0; wr = 0;
    @(negedge clk);
    check("rd+wr pre-write", d_out, 32'h0);
    rchk(0, A_CTRL, 32'h1, "rd+wr write lands");
    wr_reg(0, A_CTRL, 32'h0);
    wr = 1; addr = A_DATA; d_in = 32'd77;
    tick();
    wr = 0;
    rchk(0, A_STATUS, 32'h0, "wr without cs");
    wr_reg(0, A_UNMAP, 32'hFFFF_FFFF);
    rchk(0, A_UNMAP, 32'h0, "unmapped read");

    wr_reg(0, A_DATA, 32'd1234);
    for (int k = 1; k <= 4; k++) rchk(0, A_STATUS, 32'h1, "1234 busy");
    #2 reset = 1;
    model_reset();
    #1 check("async reset d_out", d_out, 32'h0);
    idle(2);
    @(negedge clk);
    reset = 0;
    rchk(0, A_STATUS, 32'h0, "post-reset STATUS");
    rchk(0, A_RESULT, 32'h0, "post-reset RESULT");
    rchk(0, A_DATA, 32'h0, "post-reset DATA");
    wr_reg(0, A_DATA, 32'd42);
    idle(W);
    rchk(0, A_RESULT, 32'h42, "42 after reset");

    wr_reg(1, A_DATA, 32'd67108863);
    idle(W2 - 1);
    rchk(1, A_RESULT, 32'h0, "w26 RESULT before done");
    rchk(1, A_STATUS, 32'h2, "w26 STATUS done");
    rchk(1, A_RESULT, 32'h67108863, "w26 RESULT");
    wr_reg(1, A_UNMAP, 32'h1234_5678);
    rchk(1, A_UNMAP, 32'h0, "w26 unmapped read");
    rchk(1, A_DATA, 32'h03FF_FFFF, "w26 DATA unchanged");
    rchk(1, A_RESULT, 32'h67108863, "w26 RESULT unchanged");
    rchk(1, A_STATUS, 32'h0, "w26 STATUS unchanged");

    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
